row_window_buffer: RTL

ROW_WINDOW_BUFFER -- requirements
Module: row_window_buffer

---
 rtl/row_window_buffer_pkg.sv | 15 +
 rtl/row_window_buffer_line_mem.sv | 24 ++
 rtl/row_window_buffer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/row_window_buffer_pkg.sv
// Shared types and default geometry for the row window buffer.
package row_window_buffer_pkg;

  // Row-fill phases: the first two rows of a frame only prime the line memories.
  typedef enum logic [1:0] {
    FILL0  = 2'd0,
    FILL1  = 2'd1,
    STREAM = 2'd2
  } rwb_state_e;

  localparam int unsigned DEF_IMG_W  = 32;
  localparam int unsigned DEF_IMG_H  = 32;
  localparam int unsigned DEF_DATA_W = 8;

endpackage

// File: rtl/row_window_buffer_line_mem.sv
// Single-port row memory: synchronous write, combinational read at the same address.
module line_mem #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write the addressed column; storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/row_window_buffer.sv
// Row window buffer: turns a raster pixel stream into vertical triples
// (rows r-2, r-1, r at one column) for a downstream 3x3 kernel stage.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FILL0  | consuming row 0 of the frame, no output
// FILL1  | consuming row 1 of the frame, no output
// STREAM | rows 2..IMG_H-1, every accepted beat yields a triple
//
// reset_n is active-high despite its name. An accepted beat carrying in_sof
// is processed as column 0 / row 0 / FILL0 regardless of the live counters.
module row_window_buffer
  import row_window_buffer_pkg::*;
#(
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_pix,
  input  logic                     in_sof,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        R1,
  output logic [DATA_W-1:0]        R2,
  output logic [DATA_W-1:0]        R3,
  output logic [$clog2(IMG_W)-1:0] out_col,
  output logic                     out_eol,
  output logic                     frame_done
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  rwb_state_e        state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] r1_q, r1_d;
  logic [DATA_W-1:0] r2_q, r2_d;
  logic [DATA_W-1:0] r3_q, r3_d;
  logic [COL_W-1:0]  out_col_q, out_col_d;
  logic              out_eol_q, out_eol_d;
  logic              last_q, last_d;

  logic              accept;
  rwb_state_e        beat_state;
  logic [COL_W-1:0]  beat_col;
  logic [ROW_W-1:0]  beat_row;
  logic              col_wrap;
  logic              row_wrap;
  logic [DATA_W-1:0] line1_rd;
  logic [DATA_W-1:0] line2_rd;

  // Accept whenever the output slot is free or being drained this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !reset_n;

  // Start-of-frame overrides the live position for the beat that carries it.
  assign beat_state = in_sof ? FILL0 : state_q;
  assign beat_col   = in_sof ? '0    : col_q;
  assign beat_row   = in_sof ? '0    : row_q;
  assign col_wrap   = (beat_col == COL_LAST);
  assign row_wrap   = (beat_row == ROW_LAST);

  // line1 holds row r-1, line2 holds row r-2; both shift down by one row per beat.
  line_mem #(
    .DEPTH  (IMG_W),
    .DATA_W (DATA_W)
  ) u_line1 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (beat_col),
    .wdata_i (in_pix),
    .rdata_o (line1_rd)
  );

  line_mem #(
    .DEPTH  (IMG_W),
    .DATA_W (DATA_W)
  ) u_line2 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (beat_col),
    .wdata_i (line1_rd),
    .rdata_o (line2_rd)
  );

  // Next position and fill phase; phase changes only at the end of a row.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (accept) begin
      state_d = beat_state;
      row_d   = beat_row;
      col_d   = col_wrap ? '0 : beat_col + COL_W'(1);
      if (col_wrap) begin
        row_d = row_wrap ? '0 : beat_row + ROW_W'(1);
        case (beat_state)
          FILL0:   state_d = FILL1;
          FILL1:   state_d = STREAM;
          STREAM:  state_d = row_wrap ? FILL0 : STREAM;
          default: state_d = FILL0;
        endcase
      end
    end
  end

  // Output slot: load a new triple on accept, otherwise hold until drained.
  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    r1_d        = r1_q;
    r2_d        = r2_q;
    r3_d        = r3_q;
    out_col_d   = out_col_q;
    out_eol_d   = out_eol_q;
    last_d      = last_q;
    if (accept) begin
      out_valid_d = (beat_state == STREAM);
      r1_d        = line2_rd;
      r2_d        = line1_rd;
      r3_d        = in_pix;
      out_col_d   = beat_col;
      out_eol_d   = col_wrap;
      last_d      = (beat_state == STREAM) && col_wrap && row_wrap;
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q     <= FILL0;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      r1_q        <= '0;
      r2_q        <= '0;
      r3_q        <= '0;
      out_col_q   <= '0;
      out_eol_q   <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      r3_q        <= r3_d;
      out_col_q   <= out_col_d;
      out_eol_q   <= out_eol_d;
      last_q      <= last_d;
    end
  end

  // Frame completion is signalled in the same cycle the final triple is taken.
  assign frame_done = !reset_n && out_valid_q && out_ready && last_q;

  assign out_valid = out_valid_q;
  assign R1        = r1_q;
  assign R2        = r2_q;
  assign R3        = r3_q;
  assign out_col   = out_col_q;
  assign out_eol   = out_eol_q;

endmodule
